// File: rtl/shift_reg_univ.sv
// Universal WIDTH-bit shift register: load, clear, hold, and multi-step
// shifts/rotates sequenced by a start/busy/done handshake.
module shift_reg_univ #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned AMT_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [AMT_W-1:0] amt,
    input  logic [WIDTH-1:0] d,
    input  logic             sin,
    output logic [WIDTH-1:0] q,
    output logic             sout,
    output logic             busy,
    output logic             done
);

    localparam logic [2:0] OP_HOLD = 3'b000;
    localparam logic [2:0] OP_LOAD = 3'b001;
    localparam logic [2:0] OP_SHL  = 3'b010;
    localparam logic [2:0] OP_SHR  = 3'b011;
    localparam logic [2:0] OP_ROL  = 3'b100;
    localparam logic [2:0] OP_ROR  = 3'b101;
    localparam logic [2:0] OP_ASR  = 3'b110;
    localparam logic [2:0] OP_CLR  = 3'b111;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   q_q, q_d;
    logic               sout_q, sout_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic [AMT_W-1:0]   cnt_q, cnt_d;
    logic [2:0]         op_q, op_d;
    logic [WIDTH-1:0]   step_q;
    logic               step_out;
    logic               is_shift_op;

    assign is_shift_op = (op != OP_HOLD) && (op != OP_LOAD) && (op != OP_CLR);

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (start && is_shift_op) state_d = RUN;
            RUN:  if (cnt_q == '0)          state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Result of one single-bit step of the latched operation
    always_comb begin
        step_q   = q_q;
        step_out = sout_q;
        case (op_q)
            OP_SHL: begin step_q = {q_q[WIDTH-2:0], sin};        step_out = q_q[WIDTH-1]; end
            OP_SHR: begin step_q = {sin, q_q[WIDTH-1:1]};        step_out = q_q[0];       end
            OP_ROL: begin step_q = {q_q[WIDTH-2:0], q_q[WIDTH-1]}; step_out = q_q[WIDTH-1]; end
            OP_ROR: begin step_q = {q_q[0], q_q[WIDTH-1:1]};     step_out = q_q[0];       end
            OP_ASR: begin step_q = {q_q[WIDTH-1], q_q[WIDTH-1:1]}; step_out = q_q[0];     end
            default: ;
        endcase
    end

    // Output and datapath next values
    always_comb begin
        q_d    = q_q;
        sout_d = sout_q;
        cnt_d  = cnt_q;
        op_d   = op_q;
        done_d = 1'b0;
        busy_d = (state_d == RUN);
        case (state_q)
            IDLE: begin
                if (start) begin
                    case (op)
                        OP_HOLD: done_d = 1'b1;
                        OP_LOAD: begin q_d = d;  done_d = 1'b1; end
                        OP_CLR:  begin q_d = '0; done_d = 1'b1; end
                        default: begin
                            op_d  = op;
                            cnt_d = amt;
                        end
                    endcase
                end
            end
            RUN: begin
                if (cnt_q != '0) begin
                    q_d    = step_q;
                    sout_d = step_out;
                    cnt_d  = cnt_q - AMT_W'(1);
                end else begin
                    done_d = 1'b1;
                end
            end
            default: ;
        endcase
    end

    // Datapath and output registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            q_q    <= '0;
            sout_q <= 1'b0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
            cnt_q  <= '0;
            op_q   <= OP_HOLD;
        end else begin
            q_q    <= q_d;
            sout_q <= sout_d;
            busy_q <= busy_d;
            done_q <= done_d;
            cnt_q  <= cnt_d;
            op_q   <= op_d;
        end
    end

    assign q    = q_q;
    assign sout = sout_q;
    assign busy = busy_q;
    assign done = done_q;

endmodule
